fixed_to_floating_pipelined: RTL and testbench

//  Streaming successor to the start/ready fixed-to-float converter. Converts a signed or unsigned
//  Q(INTEGER).(FRACTION) fixed-point word to IEEE-style float (1/E/M) in a 3-stage pipeline.

---
 rtl/fixed_to_floating_pipelined.sv | 132 +++++++++++++
 tb/tb_fixed_to_floating_pipelined.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_floating_pipelined.sv
// rtl/fixed_to_floating_pipelined.sv - 3-stage streaming fixed-point to float converter
// Stages: magnitude, leading-one normalise, round/pack; the whole pipe freezes on output stall.
module fixed_to_floating_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int bias       = 2**(E-1)-1,
  parameter int INTEGER    = 10,
  parameter int FRACTION   = 22,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] fixed_point_input,
  input  logic                  rnd_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] floating_point_output
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = $clog2(W);
  localparam int G  = W - 2 - M;
  localparam int FRAC_BITS = (INTEGER + FRACTION == DATA_WIDTH) ? FRACTION : DATA_WIDTH - INTEGER;
  localparam logic [E-1:0] EXP_OFFSET = E'(bias - FRAC_BITS);

  logic stall;
  logic ready_en;
  logic take;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ready_en & ~stall;
  assign take     = in_valid & in_ready;

  // Stage 1: sign and magnitude; the most negative input negates to 2^(W-1) unsigned.
  logic         sign_in;
  logic [W-1:0] mag_in;
  logic         v1, sign1, rnd1;
  logic [W-1:0] mag1;

  always_comb begin
    sign_in = (SIGNED != 0) & fixed_point_input[W-1];
    mag_in  = sign_in ? (~fixed_point_input + W'(1)) : fixed_point_input;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
      v1       <= 1'b0;
      sign1    <= 1'b0;
      rnd1     <= 1'b0;
      mag1     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (!stall) begin
        v1 <= take;
        if (take) begin
          sign1 <= sign_in;
          rnd1  <= rnd_mode;
          mag1  <= mag_in;
        end
      end
    end
  end

  // Stage 2: leading-one position, normalising shift and biased exponent.
  logic [PW-1:0] lod_pos;
  logic [W-1:0]  norm_c;
  logic [E-1:0]  exp_c;
  logic          v2, sign2, rnd2, zero2;
  logic [W-2:0]  norm2;
  logic [E-1:0]  exp2;

  always_comb begin
    lod_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (mag1[i]) lod_pos = PW'(i);
    end
    norm_c = mag1 << (PW'(W-1) - lod_pos);
    exp_c  = E'(lod_pos) + EXP_OFFSET;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      rnd2  <= 1'b0;
      zero2 <= 1'b0;
      norm2 <= '0;
      exp2  <= '0;
    end else if (!stall) begin
      v2 <= v1;
      if (v1) begin
        sign2 <= sign1;
        rnd2  <= rnd1;
        zero2 <= ~|mag1;
        norm2 <= norm_c[W-2:0];
        exp2  <= exp_c;
      end
    end
  end

  // Stage 3: round. Small magnitudes shift zeros into guard/sticky, so they never round.
  logic [M-1:0] mant;
  logic         guard, sticky, inc;
  logic [M:0]   mant_sum;
  logic [E-1:0] exp_out;
  logic [W-1:0] result;

  always_comb begin
    mant     = norm2[W-2 -: M];
    guard    = norm2[G];
    sticky   = |norm2[G-1:0];
    inc      = ~rnd2 & guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {{M{1'b0}}, inc};
    exp_out  = exp2 + {{(E-1){1'b0}}, mant_sum[M]};
    result   = zero2 ? '0 : {sign2, exp_out, mant_sum[M-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid             <= 1'b0;
      floating_point_output <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      if (v2) floating_point_output <= result;
    end
  end

endmodule

// File: tb/tb_fixed_to_floating_pipelined.sv
// tb/tb_fixed_to_floating_pipelined.sv - randomized scoreboard bench for fixed_to_floating_pipelined
// Expected floats come from an arithmetic model using quotient/remainder rounding.
module tb_fixed_to_floating_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fixed_point_input = '0;
  logic        rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] floating_point_output;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;
  logic [31:0] exp_q[$];
  int fire_log[$];
  bit accepted;
  bit seen_valid;

  always #5 clk = ~clk;

  fixed_to_floating_pipelined dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fixed_point_input(fixed_point_input),
    .rnd_mode(rnd_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .floating_point_output(floating_point_output)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
  endtask

  // Q10.22 signed to 1/8/23 float: value = mag * 2^-22, rounded by remainder against half-ulp.
  function automatic logic [31:0] ref_conv(input logic [31:0] x, input bit trunc);
    longint unsigned xv, mag, q, rem, half;
    bit s;
    int p, sh, ex;
    xv  = longint'(x);
    s   = x[31];
    mag = s ? (64'h1_0000_0000 - xv) : xv;
    if (mag == 0) return 32'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!trunc && (rem > half || (rem == half && q[0]))) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    ex = p - 22 + 127;
    return {s, ex[7:0], q[22:0]};
  endfunction

  task automatic step(input bit iv, input logic [31:0] d, input bit rm,
                      input logic [31:0] e, input bit ordy);
    @(negedge clk);
    in_valid = iv;
    fixed_point_input = d;
    rnd_mode = rm;
    out_ready = ordy;
    #1;
    cycle++;
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
    seen_valid = out_valid;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        check_eq("out_data", floating_point_output, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          fire_log.push_back(cycle);
        end
      end
    end
    accepted = iv && in_ready;
    if (accepted) exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input bit rm, input logic [31:0] e);
    int n = 0;
    do begin
      step(1'b1, d, rm, e, 1'b1);
      n++;
    end while (!accepted && n < 50);
    if (!accepted) check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check_eq("drained", 32'(exp_q.size()), 32'd0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_fixed();
    logic [31:0] x;
    x = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
    if ($urandom_range(0, 15) == 0) x = 32'h0;
    return x;
  endfunction

  initial begin
    logic [31:0] x;
    bit rm;
    int lat;
    bit found;
    int s;

    #1;
    check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset_out_data", floating_point_output, 32'h0);
    check_eq("reset_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("in_ready_before_first_edge", {31'b0, in_ready}, 32'd0);

    // Latency from accept to out_valid with an empty pipe.
    step(1'b1, 32'h0040_0000, 1'b0, 32'h3F80_0000, 1'b1);
    check_eq("t1_accept", {31'b0, accepted}, 32'd1);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      if (seen_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    check_eq("t1_latency", lat, 32'd3);

    send(32'hFFA0_0000, 1'b0, 32'hBFC0_0000);
    send(32'h0000_0000, 1'b0, 32'h0000_0000);
    send(32'h8000_0000, 1'b0, 32'hC400_0000);
    send(32'h0000_0001, 1'b0, 32'h3480_0000);
    send(32'h7FFF_FFFF, 1'b0, 32'h4400_0000);
    send(32'h7FFF_FFFF, 1'b1, 32'h43FF_FFFF);
    send(32'h0100_0001, 1'b0, 32'h4080_0000);
    // guard=1 with odd lsb rounds mantissa 1 up to 2
    send(32'h0100_0003, 1'b0, 32'h4080_0002);
    send(32'h0100_0003, 1'b1, 32'h4080_0001);
    drain();

    fire_log.delete();
    for (int i = 0; i < 8; i++) begin
      x = rand_fixed();
      rm = 1'($urandom_range(0, 1));
      send(x, rm, ref_conv(x, rm));
    end
    drain();
    check_eq("b2b_count", 32'(fire_log.size()), 32'd8);
    if (fire_log.size() == 8) check_eq("b2b_consecutive", 32'(fire_log[7] - fire_log[0]), 32'd7);

    fire_log.delete();
    s = 0;
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      x = rand_fixed();
      rm = 1'($urandom_range(0, 1));
      do begin
        step(1'b1, x, rm, ref_conv(x, rm), !(s >= 4 && s < 9));
        s++;
        n++;
      end while (!accepted && n < 50);
      if (!accepted) check_eq("bp_accept_timeout", {31'b0, in_ready}, 32'd1);
    end
    drain();
    check_eq("bp_count", 32'(fire_log.size()), 32'd12);

    for (int i = 0; i < 400; i++) begin
      x = rand_fixed();
      rm = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), x, rm, ref_conv(x, rm), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    fire_log.delete();
    for (int i = 0; i < 3; i++) send(32'h0040_0000 + 32'(i), 1'b0, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_data", floating_point_output, 32'h0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_release_in_ready", {31'b0, in_ready}, 32'd0);
    send(32'h0040_0000, 1'b0, 32'h3F80_0000);
    drain();
    check_eq("rst_single_output", 32'(fire_log.size()), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
